// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit.
//
// A WIDTH-bit add or subtract is cut into STAGES ripple segments of
// SEG = WIDTH/STAGES bits, one segment per register stage. Every stage
// carries the full operands, the partial sum built so far and the segment
// carry forward. Operands enter through a valid/ready handshake. The last
// stage register drives the result outputs directly.
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   in_valid      operands present
//   in_ready      pipeline can accept this cycle (combinational)
//   in_a, in_b    operands
//   in_cin        carry-in, used in add mode only
//   in_sub        0 = add, 1 = subtract
//   out_valid     result present
//   out_ready     consumer accepts result
//   out_sum       result bits
//   out_carry     carry-out (subtract: 1 = no borrow)
//   out_overflow  two's-complement signed overflow

package soc_pkg;
  localparam int DATA_WIDTH = 32;
endpackage

module pipelined_addsub #(
  parameter int WIDTH  = soc_pkg::DATA_WIDTH,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_overflow
);

  localparam int SEG = WIDTH / STAGES;
  localparam logic [WIDTH-1:0] SEG_ONES = WIDTH'({SEG{1'b1}});

  if ((WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_addsub: STAGES must divide WIDTH exactly");
  end

  // Stage registers
  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_carry;
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic              r_ovf;

  // Per-stage source values (from the inputs for stage 0, else from stage k-1)
  logic [STAGES-1:0] w_src_v;
  logic [STAGES-1:0] w_src_c;
  logic [WIDTH-1:0]  w_src_a   [STAGES];
  logic [WIDTH-1:0]  w_src_b   [STAGES];
  logic [WIDTH-1:0]  w_src_sum [STAGES];
  logic [SEG:0]      w_seg     [STAGES];
  logic [WIDTH-1:0]  w_nxt_sum [STAGES];
  logic [STAGES-1:0] w_ready;
  logic              w_last_ovf;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      // Subtract is a + ~b + 1, so the inversion and the forced carry-in
      // happen once here and the rest of the pipe only ever adds.
      assign w_src_v[k]   = in_valid;
      assign w_src_a[k]   = in_a;
      assign w_src_b[k]   = in_sub ? ~in_b : in_b;
      assign w_src_c[k]   = in_sub | in_cin;
      assign w_src_sum[k] = '0;
    end else begin : g_body
      assign w_src_v[k]   = r_valid[k-1];
      assign w_src_a[k]   = r_a[k-1];
      assign w_src_b[k]   = r_b[k-1];
      assign w_src_c[k]   = r_carry[k-1];
      assign w_src_sum[k] = r_sum[k-1];
    end

    // The only ripple between two registers: one SEG-bit segment.
    assign w_seg[k] = {1'b0, w_src_a[k][k*SEG +: SEG]}
                    + {1'b0, w_src_b[k][k*SEG +: SEG]}
                    + (SEG+1)'(w_src_c[k]);

    assign w_nxt_sum[k] = (w_src_sum[k] & ~(SEG_ONES << (k*SEG)))
                        | (WIDTH'(w_seg[k][SEG-1:0]) << (k*SEG));

    // Unrolled form of ready[k] = !valid[k] || ready[k+1]: a stage can move
    // when any stage at or after it is empty, or the consumer takes a result.
    assign w_ready[k] = out_ready || !(&r_valid[STAGES-1:k]);
  end

  // Sign of the sum is only known once the top segment is done.
  assign w_last_ovf =
      (w_src_a[STAGES-1][WIDTH-1] == w_src_b[STAGES-1][WIDTH-1]) &&
      (w_nxt_sum[STAGES-1][WIDTH-1] != w_src_a[STAGES-1][WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_carry <= '0;
      r_ovf   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_ready[k]) begin
          r_valid[k] <= w_src_v[k];
          // Data is only captured for real operations; bubbles leave it alone.
          if (w_src_v[k]) begin
            r_a[k]     <= w_src_a[k];
            r_b[k]     <= w_src_b[k];
            r_sum[k]   <= w_nxt_sum[k];
            r_carry[k] <= w_seg[k][SEG];
          end
        end
      end
      if (w_ready[STAGES-1] && w_src_v[STAGES-1]) begin
        r_ovf <= w_last_ovf;
      end
    end
  end

  assign in_ready     = w_ready[0];
  assign out_valid    = r_valid[STAGES-1];
  assign out_sum      = r_sum[STAGES-1];
  assign out_carry    = r_carry[STAGES-1];
  assign out_overflow = r_ovf;

endmodule

// File: tb/tb_pipelined_addsub.sv
module tb_pipelined_addsub;

  localparam int W = 8;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_cin, in_sub;
  logic [W-1:0] in_a, in_b;
  logic         out_valid, out_ready, out_carry, out_overflow;
  logic [W-1:0] out_sum;

  int n_checks = 0;
  int n_fail   = 0;
  int n_in     = 0;
  int n_out    = 0;

  logic [33:0] exp_q[$];
  logic [33:0] exp_v;
  bit          aux_go = 1'b0;
  bit   [1:0]  aux_done = 2'b00;

  logic         hold_armed = 1'b0;
  logic [W-1:0] hold_sum;
  logic         hold_c, hold_o;

  int           acc, base_in, base_out;
  logic [W-1:0] held;

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_cin      (in_cin),
    .in_sub      (in_sub),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_carry   (out_carry),
    .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {overflow, carry, sum} from plain integer arithmetic.
  function automatic logic [33:0] model(input int w, input longint a, input longint b,
                                        input logic cin, input logic sub);
    longint mask, lim, full, sa, sb, sres;
    logic [33:0] r;
    mask = (longint'(1) << w) - 1;
    lim  = longint'(1) << (w - 1);
    sa   = (a >= lim) ? a - (mask + 1) : a;
    sb   = (b >= lim) ? b - (mask + 1) : b;
    if (sub) begin
      full = a + ((~b) & mask) + 1;
      sres = sa - sb;
    end else begin
      full = a + b + longint'(cin);
      sres = sa + sb + longint'(cin);
    end
    r = '0;
    r[31:0] = 32'(full & mask);
    r[32]   = ((full >> w) & 1) != 0;
    r[33]   = (sres >= lim) || (sres < -lim);
    return r;
  endfunction

  // Scoreboard and hold-stability monitor for the main instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_armed = 1'b0;
    end else begin
      if (hold_armed) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_sum", out_sum, hold_sum);
        check_eq("hold_carry", out_carry, hold_c);
        check_eq("hold_ovf", out_overflow, hold_o);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(W, longint'(in_a), longint'(in_b), in_cin, in_sub));
        n_in++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("out_without_in", exp_q.size(), 1);
        end else begin
          exp_v = exp_q.pop_front();
          check_eq("sb_sum", out_sum, exp_v[W-1:0]);
          check_eq("sb_carry", out_carry, exp_v[32]);
          check_eq("sb_ovf", out_overflow, exp_v[33]);
        end
        n_out++;
      end
      hold_armed = out_valid && !out_ready;
      hold_sum   = out_sum;
      hold_c     = out_carry;
      hold_o     = out_overflow;
    end
  end

  // Extra configurations under random handshake traffic.
  for (genvar g = 0; g < 2; g++) begin : g_aux
    localparam int AW = (g == 0) ? 16 : 8;
    localparam int AS = (g == 0) ? 2 : 1;

    logic          a_iv, a_ir, a_cin, a_sub, a_ov, a_or, a_oc, a_oo;
    logic [AW-1:0] a_a, a_b, a_sum;
    logic [33:0]   a_q[$];
    logic [33:0]   a_exp;
    int            a_in  = 0;
    int            a_out = 0;

    pipelined_addsub #(.WIDTH(AW), .STAGES(AS)) u_aux (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (a_iv),
      .in_ready    (a_ir),
      .in_a        (a_a),
      .in_b        (a_b),
      .in_cin      (a_cin),
      .in_sub      (a_sub),
      .out_valid   (a_ov),
      .out_ready   (a_or),
      .out_sum     (a_sum),
      .out_carry   (a_oc),
      .out_overflow(a_oo)
    );

    always @(negedge clk) begin
      if (rst_n) begin
        if (a_iv && a_ir) begin
          a_q.push_back(model(AW, longint'(a_a), longint'(a_b), a_cin, a_sub));
          a_in++;
        end
        if (a_ov && a_or) begin
          if (a_q.size() == 0) begin
            check_eq("aux_out_without_in", a_q.size(), 1);
          end else begin
            a_exp = a_q.pop_front();
            check_eq("aux_sum", a_sum, a_exp[AW-1:0]);
            check_eq("aux_carry", a_oc, a_exp[32]);
            check_eq("aux_ovf", a_oo, a_exp[33]);
          end
          a_out++;
        end
      end
    end

    initial begin
      a_iv = 1'b0; a_or = 1'b0; a_a = '0; a_b = '0; a_cin = 1'b0; a_sub = 1'b0;
      wait (aux_go);
      for (int c = 0; c < 8000 && a_in < 500; c++) begin
        @(posedge clk); #1;
        a_iv  = 1'($urandom_range(0, 1));
        a_or  = 1'($urandom_range(0, 1));
        a_a   = AW'($urandom);
        a_b   = AW'($urandom);
        a_cin = 1'($urandom_range(0, 1));
        a_sub = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      a_iv = 1'b0;
      a_or = 1'b1;
      for (int c = 0; c < 20 && a_q.size() != 0; c++) @(negedge clk);
      check_eq("aux_accepted", a_in, 500);
      check_eq("aux_drained", a_out, 500);
      check_eq("aux_queue_empty", a_q.size(), 0);
      aux_done[g] = 1'b1;
    end
  end

  task automatic drive_rand();
    in_a   = W'($urandom);
    in_b   = W'($urandom);
    in_cin = 1'($urandom_range(0, 1));
    in_sub = 1'($urandom_range(0, 1));
  endtask

  task automatic send_dir(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub,
                          input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    check_eq({tag, "_latency"}, n, S);
    check_eq({tag, "_sum"}, out_sum, es);
    check_eq({tag, "_carry"}, out_carry, ec);
    check_eq({tag, "_ovf"}, out_overflow, eo);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #11;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_sum", out_sum, 0);
    check_eq("rst_out_carry", out_carry, 0);
    check_eq("rst_out_ovf", out_overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("rst_in_ready", in_ready, 1);

    // Directed arithmetic corners
    send_dir("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    send_dir("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    send_dir("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    send_dir("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Back-to-back stream, full throughput
    out_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      in_valid = (i < 20);
      drive_rand();
      @(negedge clk);
      if (i < 20) check_eq("stream_in_ready", in_ready, 1);
      check_eq("stream_out_valid", out_valid, (i >= 4 && i < 24));
    end

    // Fill under stall, then drain
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive_rand();
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      if (i == 6) held = out_sum;
    end
    check_eq("stall_accepted", acc, S);
    check_eq("stall_in_ready", in_ready, 0);
    check_eq("stall_out_valid", out_valid, 1);
    check_eq("stall_frozen_sum", out_sum, held);
    base_out = n_out;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("stall_drained", n_out - base_out, S);
    check_eq("stall_queue_empty", exp_q.size(), 0);

    // Random handshake traffic on all instances
    aux_go   = 1'b1;
    base_in  = n_in;
    base_out = n_out;
    for (int c = 0; c < 8000 && (n_in - base_in) < 500; c++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      drive_rand();
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
    check_eq("rand_accepted", n_in - base_in, 500);
    check_eq("rand_drained", n_out - base_out, 500);
    check_eq("rand_queue_empty", exp_q.size(), 0);
    for (int c = 0; c < 20000 && aux_done != 2'b11; c++) @(negedge clk);
    check_eq("aux_finished", aux_done, 2'b11);

    // Reset with operations in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      drive_rand();
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("pre_rst_out_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_out_sum", out_sum, 0);
    check_eq("mid_rst_out_carry", out_carry, 0);
    check_eq("mid_rst_out_ovf", out_overflow, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_dir("post_rst", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("post_rst_alone", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined successor to the combinational ripple-carry adder in soc_pkg-based datapaths.
- Splits a WIDTH-bit add/subtract into STAGES carry-ripple segments, one segment per register stage.
- Accepts one operation per cycle through a valid/ready handshake and returns sum, carry and signed overflow after STAGES cycles.
- Supports back-pressure without data loss.

Parameters:
- WIDTH, soc_pkg::DATA_WIDTH, operand/result width in bits.
- STAGES, 4, number of pipeline segments. Must divide WIDTH exactly; elaboration error otherwise. STAGES=1 is legal.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  pipeline can accept this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in, add mode only
- in_sub  input  1  0 = add, 1 = subtract
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  result
- out_carry  output  1  carry-out (subtract: 1 = no borrow)
- out_overflow  output  1  two's-complement signed overflow

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0 and all data registers 0. out_valid=0, out_sum=0, out_carry=0, out_overflow=0. in_ready=1 once reset is released.
- Arithmetic:
  - Add: out_sum = in_a + in_b + in_cin.
  - Subtract: out_sum = in_a + ~in_b + 1; in_cin is ignored.
  - {out_carry, out_sum} is the WIDTH+1-bit result.
  - Overflow is set when the operand sign bits (after the B inversion) are equal and the sum sign bit differs.
- Segmentation:
  - SEG = WIDTH/STAGES.
  - Stage k (0..STAGES-1) adds bits [k*SEG +: SEG] using the carry registered by stage k-1. Stage 0 uses the effective carry-in.
  - Unprocessed operand bits and already-completed sum bits travel forward in the stage registers.
  - Only one SEG-bit ripple lies between any two registers.
- Handshake:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - ready[k] = !valid[k] || ready[k+1], with ready[STAGES] = out_ready. in_ready = ready[0] (combinational, no skid buffer).
  - Stage k loads from stage k-1 when ready[k]. Its valid bit becomes valid[k-1], or for stage 0 in_valid && in_ready.
  - A stage that is not ready holds its data and valid bit unchanged.
  - The final stage register drives the outputs directly (registered outputs).
- Latency and throughput:
  - Latency is exactly STAGES cycles from the input transfer to out_valid, with no stalls.
  - Throughput is 1 op/cycle while out_ready=1.
- Boundary conditions:
  - Full pipeline with out_ready=0: in_ready=0, all STAGES results held, none lost or duplicated.
  - Bubbles collapse: an empty stage accepts data even under downstream stall.
  - A simultaneous input accept and output drain on a full pipeline is legal and keeps occupancy unchanged.
  - Input signals are ignored when in_ready=0.
  - Reset mid-operation discards all in-flight results. out_valid drops asynchronously.
  - Results exit in input order.
  - out_* values are held stable while out_valid && !out_ready.

Test Plan (WIDTH=8, STAGES=4 unless stated):
- Add 0xFF + 0x01, cin=0 -> after 4 cycles: sum 0x00, carry 1, overflow 0. Add 0x7F + 0x01 -> sum 0x80, carry 0, overflow 1.
- Sub 0x05 - 0x07 with cin=1 (ignored) -> sum 0xFE, carry 0, overflow 0. Sub 0x80 - 0x01 -> sum 0x7F, carry 1, overflow 1.
- Stream 20 random ops back-to-back with out_ready=1 -> in_ready constantly 1, one result per cycle starting cycle 4, all match the reference model {a+b+cin} / {a+~b+1}, order preserved.
- Hold out_ready=0 and drive in_valid=1 continuously -> exactly 4 ops accepted, then in_ready=0. Outputs frozen. Raise out_ready -> 4 results drain in order, no duplicates.
- Random in_valid/out_ready toggling (50% each) for 500 ops, also with WIDTH=16/STAGES=2 and WIDTH=8/STAGES=1 -> scoreboard 0 mismatches, 0 lost ops.
- Assert rst_n low with 3 ops in flight -> out_valid=0 and outputs 0 immediately. After release, the first new op emerges alone after 4 cycles.
